// File: rtl/execute_branch_predict_btb.sv
// Branch target buffer for the execute stage: registered fetch-side lookup, execute-side update and prediction check.
// Optional 2-bit saturating counters are enabled by defining MIST32E10FA_BRANCH_PREDICT_COUNTER_EN.
module execute_branch_predict_btb #(
  parameter int P_ENTRY_N = 16
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iFETCH_REQ,
  input  logic [31:0] iFETCH_ADDR,
  output logic        oFETCH_PREDICT_ENA,
  output logic [31:0] oFETCH_PREDICT_ADDR,
  input  logic        iSTATE_NORMAL,
  input  logic        iPREV_VALID,
  input  logic        iPREV_EX_BRANCH,
  input  logic        iNEXT_BUSY,
  input  logic [31:0] iPREV_BRANCH_PC,
  input  logic        iPREV_BRANCH_PREDICT_ENA,
  input  logic [31:0] iPREV_BRANCH_PREDICT_ADDR,
  input  logic        iPREV_BRANCH_VALID,
  input  logic        iPREV_BRANCH_IB_VALID,
  input  logic [31:0] iPREV_JUMP_ADDR,
  output logic        oNEXT_PREDICT_HIT,
  output logic        oBUSY
);

  localparam int P_INDEX_W = $clog2(P_ENTRY_N);
  localparam int P_TAG_W   = 30 - P_INDEX_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [P_INDEX_W-1:0]   r_walk_cnt;
  logic [P_INDEX_W-1:0]   w_walk_next;

  logic [P_ENTRY_N-1:0]   r_valid;
  logic [P_TAG_W-1:0]     r_tag    [P_ENTRY_N];
  logic [31:0]            r_target [P_ENTRY_N];

  logic                   r_fetch_ena;
  logic [31:0]            r_fetch_addr;

  logic                   w_busy;
  logic                   w_accept;
  logic                   w_do_update;
  logic                   w_wr_taken;
  logic [P_INDEX_W-1:0]   w_fetch_idx;
  logic [P_TAG_W-1:0]     w_fetch_tag;
  logic [P_INDEX_W-1:0]   w_upd_idx;
  logic [P_TAG_W-1:0]     w_upd_tag;
  logic                   w_fetch_hit;
  logic                   w_fetch_qual;

  // Word-offset bits never take part in indexing or tagging.
  logic                   w_unused_ok;
  assign w_unused_ok = &{1'b0, iFETCH_ADDR[1:0], iPREV_BRANCH_PC[1:0]};

  assign w_fetch_idx = iFETCH_ADDR[P_INDEX_W+1:2];
  assign w_fetch_tag = iFETCH_ADDR[31:P_INDEX_W+2];
  assign w_upd_idx   = iPREV_BRANCH_PC[P_INDEX_W+1:2];
  assign w_upd_tag   = iPREV_BRANCH_PC[31:P_INDEX_W+2];

  assign w_busy      = (r_state == ST_INIT);
  assign w_accept    = iSTATE_NORMAL & iPREV_VALID & iPREV_EX_BRANCH & ~iNEXT_BUSY & ~w_busy;
  assign w_do_update = w_accept & ~iFLUSH;
  assign w_wr_taken  = w_do_update & iPREV_BRANCH_VALID;
  assign w_fetch_hit = r_valid[w_fetch_idx] & (r_tag[w_fetch_idx] == w_fetch_tag);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state    <= ST_INIT;
      r_walk_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_walk_cnt <= w_walk_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_walk_next  = r_walk_cnt;
    case (r_state)
      ST_INIT: begin
        if (iFLUSH) begin
          w_walk_next = '0;
        end else if (r_walk_cnt == P_INDEX_W'(P_ENTRY_N - 1)) begin
          w_state_next = ST_RUN;
          w_walk_next  = '0;
        end else begin
          w_walk_next = r_walk_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (iFLUSH) begin
          w_state_next = ST_INIT;
          w_walk_next  = '0;
        end
      end
      default: begin
        w_state_next = ST_INIT;
        w_walk_next  = '0;
      end
    endcase
  end

  // Table RAM has no reset; the invalidate walk is what makes it safe after power-up.
  always_ff @(posedge iCLOCK) begin
    if (w_busy) begin
      r_valid[r_walk_cnt] <= 1'b0;
    end else if (w_wr_taken) begin
      r_valid[w_upd_idx]  <= 1'b1;
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= iPREV_JUMP_ADDR;
    end
  end

`ifdef MIST32E10FA_BRANCH_PREDICT_COUNTER_EN
  logic [1:0] r_ctr [P_ENTRY_N];
  logic       w_upd_hit;
  logic       w_wr_dec;

  assign w_upd_hit    = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);
  assign w_wr_dec     = w_do_update & ~iPREV_BRANCH_VALID & ~iPREV_BRANCH_IB_VALID & w_upd_hit;
  assign w_fetch_qual = r_ctr[w_fetch_idx][1];

  // A fresh allocation starts weakly taken; a re-hit saturates upward.
  always_ff @(posedge iCLOCK) begin
    if (w_wr_taken) begin
      if (!w_upd_hit) begin
        r_ctr[w_upd_idx] <= 2'd2;
      end else if (r_ctr[w_upd_idx] != 2'd3) begin
        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
      end
    end else if (w_wr_dec && (r_ctr[w_upd_idx] != 2'd0)) begin
      r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
    end
  end
`else
  assign w_fetch_qual = 1'b1;
`endif

  // Lookup reads the table before this cycle's update lands.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_fetch_ena  <= 1'b0;
      r_fetch_addr <= 32'h0;
    end else begin
      r_fetch_ena <= iFETCH_REQ & ~w_busy & w_fetch_hit & w_fetch_qual;
      if (iFETCH_REQ && !w_busy) begin
        r_fetch_addr <= r_target[w_fetch_idx];
      end
    end
  end

  always_comb begin
    oNEXT_PREDICT_HIT = 1'b0;
    if (w_accept) begin
      if (iPREV_BRANCH_VALID) begin
        oNEXT_PREDICT_HIT = iPREV_BRANCH_PREDICT_ENA & (iPREV_BRANCH_PREDICT_ADDR == iPREV_JUMP_ADDR);
      end else begin
        oNEXT_PREDICT_HIT = ~iPREV_BRANCH_IB_VALID & ~iPREV_BRANCH_PREDICT_ENA;
      end
    end
  end

  assign oFETCH_PREDICT_ENA  = r_fetch_ena;
  assign oFETCH_PREDICT_ADDR = r_fetch_addr;
  assign oBUSY               = w_busy;

endmodule

// File: tb/tb_execute_branch_predict_btb.sv
// Self-checking bench for execute_branch_predict_btb: directed scenarios plus a randomized phase
// checked against a per-entry behavioural model of the BTB.
module tb_execute_branch_predict_btb;

   localparam int ENTRIES = 16;

   logic        clock = 1'b0;
   logic        resetN = 1'b1;
   logic        flush, fetchReq;
   logic [31:0] fetchAddr;
   logic        fetchPredEna;
   logic [31:0] fetchPredAddr;
   logic        stateNormal, prevValid, prevExBranch, nextBusy;
   logic [31:0] branchPc;
   logic        predEna;
   logic [31:0] predAddr;
   logic        branchValid, ibValid;
   logic [31:0] jumpAddr;
   logic        nextHit, busy;

   int nCompared = 0;
   int nMismatched = 0;
   int busyCycles;

   // Reference model: one slot per index holding the full branch PC, target and confidence.
   int          mInitLeft;
   bit          mValid  [ENTRIES];
   logic [31:0] mPc     [ENTRIES];
   logic [31:0] mTarget [ENTRIES];
   int          mCtr    [ENTRIES];

   execute_branch_predict_btb #(.P_ENTRY_N(ENTRIES)) dut (
      .iCLOCK                    (clock),
      .inRESET                   (resetN),
      .iFLUSH                    (flush),
      .iFETCH_REQ                (fetchReq),
      .iFETCH_ADDR               (fetchAddr),
      .oFETCH_PREDICT_ENA        (fetchPredEna),
      .oFETCH_PREDICT_ADDR       (fetchPredAddr),
      .iSTATE_NORMAL             (stateNormal),
      .iPREV_VALID               (prevValid),
      .iPREV_EX_BRANCH           (prevExBranch),
      .iNEXT_BUSY                (nextBusy),
      .iPREV_BRANCH_PC           (branchPc),
      .iPREV_BRANCH_PREDICT_ENA  (predEna),
      .iPREV_BRANCH_PREDICT_ADDR (predAddr),
      .iPREV_BRANCH_VALID        (branchValid),
      .iPREV_BRANCH_IB_VALID     (ibValid),
      .iPREV_JUMP_ADDR           (jumpAddr),
      .oNEXT_PREDICT_HIT         (nextHit),
      .oBUSY                     (busy)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // One comparison: counts it, and on disagreement reports tag, observed and expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one execute-stage branch presentation with every accept qualifier asserted.
   task automatic applyStimulus(input logic [31:0] pc, input logic taken, input logic ib,
                                input logic pEna, input logic [31:0] pAddr, input logic [31:0] jAddr);
      stateNormal  = 1'b1;
      prevValid    = 1'b1;
      prevExBranch = 1'b1;
      nextBusy     = 1'b0;
      branchPc     = pc;
      branchValid  = taken;
      ibValid      = ib;
      predEna      = pEna;
      predAddr     = pAddr;
      jumpAddr     = jAddr;
   endtask

   // Returns the execute stage to an idle, non-accepting state.
   task automatic clearBranch();
      prevValid   = 1'b0;
      branchValid = 1'b0;
      ibValid     = 1'b0;
      predEna     = 1'b0;
      nextBusy    = 1'b0;
   endtask

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic modelReset();
      mInitLeft = ENTRIES;
      for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
   endtask

   // Checks the combinational hit flag, advances one clock, updates the model and checks registered outputs.
   task automatic stepCycle();
      bit busyNow, accept, expHit, expEna, qual, entryHit;
      logic [31:0] expAddr;
      int fi, bi;
      #1;
      busyNow = (mInitLeft > 0);
      accept  = stateNormal && prevValid && prevExBranch && !nextBusy && !busyNow;
      if (!accept)          expHit = 1'b0;
      else if (branchValid) expHit = predEna && (predAddr == jumpAddr);
      else                  expHit = !ibValid && !predEna;
      checkOutput("next_predict_hit", 32'(nextHit), 32'(expHit));

      fi = idxOf(fetchAddr);
`ifdef MIST32E10FA_BRANCH_PREDICT_COUNTER_EN
      qual = (mCtr[fi] >= 2);
`else
      qual = 1'b1;
`endif
      expEna  = fetchReq && !busyNow && mValid[fi] && (mPc[fi][31:2] == fetchAddr[31:2]) && qual;
      expAddr = mTarget[fi];

      if (flush) begin
         modelReset();
      end else if (busyNow) begin
         mInitLeft--;
      end else if (accept) begin
         bi = idxOf(branchPc);
         entryHit = mValid[bi] && (mPc[bi][31:2] == branchPc[31:2]);
         if (branchValid) begin
            mCtr[bi]    = entryHit ? ((mCtr[bi] + 1 > 3) ? 3 : mCtr[bi] + 1) : 2;
            mValid[bi]  = 1'b1;
            mPc[bi]     = branchPc;
            mTarget[bi] = jumpAddr;
         end else if (!ibValid && entryHit) begin
            mCtr[bi] = (mCtr[bi] > 0) ? mCtr[bi] - 1 : 0;
         end
      end

      @(posedge clock);
      #1;
      checkOutput("busy", 32'(busy), 32'(mInitLeft > 0));
      checkOutput("fetch_ena", 32'(fetchPredEna), 32'(expEna));
      if (expEna) checkOutput("fetch_addr", fetchPredAddr, expAddr);
   endtask

   // Counts walk cycles until oBUSY drops, bounded so a stuck walk still reaches the summary.
   task automatic countWalk(input string tag);
      busyCycles = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         busyCycles++;
         stepCycle();
      end
      checkOutput(tag, busyCycles, ENTRIES);
   endtask

   task automatic lookup(input logic [31:0] pc);
      fetchReq  = 1'b1;
      fetchAddr = pc;
      stepCycle();
      fetchReq = 1'b0;
   endtask

   // Directed scenarios followed by randomized traffic, all in one linear sequence.
   initial begin
      flush = 1'b0;
      fetchReq = 1'b1;
      fetchAddr = 32'h100;
      applyStimulus(32'h1000, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h2000);
      for (int i = 0; i < ENTRIES; i++) begin
         mPc[i] = 32'h0;
         mTarget[i] = 32'h0;
         mCtr[i] = 0;
      end
      modelReset();
      #1 resetN = 1'b0;
      #12;
      checkOutput("reset_busy", 32'(busy), 32'd1);
      checkOutput("reset_ena", 32'(fetchPredEna), 32'd0);
      checkOutput("reset_addr", fetchPredAddr, 32'h0);
      checkOutput("reset_hit", 32'(nextHit), 32'd0);

      clearBranch();
      @(negedge clock);
      resetN = 1'b1;
      countWalk("walk_len_after_reset");
      checkOutput("walk_lookup_ena", 32'(fetchPredEna), 32'd0);
      fetchReq = 1'b0;

      $display("[TB] taken branch then lookup");
      applyStimulus(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000);
      stepCycle();
      clearBranch();
      lookup(32'h1000);
      checkOutput("taken_lookup_ena", 32'(fetchPredEna), 32'd1);
      checkOutput("taken_lookup_addr", fetchPredAddr, 32'h2000);
      stepCycle();
      checkOutput("idle_ena", 32'(fetchPredEna), 32'd0);
      checkOutput("idle_addr_hold", fetchPredAddr, 32'h2000);

      $display("[TB] two not-taken resolutions");
      applyStimulus(32'h1000, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h1004);
      stepCycle();
      stepCycle();
      clearBranch();
      lookup(32'h1000);
`ifdef MIST32E10FA_BRANCH_PREDICT_COUNTER_EN
      checkOutput("weakened_ena", 32'(fetchPredEna), 32'd0);
`else
      checkOutput("weakened_ena", 32'(fetchPredEna), 32'd1);
`endif

      $display("[TB] wrong target and stalled update");
      applyStimulus(32'h1004, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5000);
      stepCycle();
      applyStimulus(32'h1004, 1'b1, 1'b0, 1'b1, 32'h5000, 32'h6000);
      nextBusy = 1'b1;
      #1 checkOutput("stalled_hit", 32'(nextHit), 32'd0);
      stepCycle();
      clearBranch();
      lookup(32'h1004);
      checkOutput("stalled_no_write", fetchPredAddr, 32'h5000);
      applyStimulus(32'h1004, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h2004);
      #1 checkOutput("wrong_target_hit", 32'(nextHit), 32'd0);
      stepCycle();
      applyStimulus(32'h1004, 1'b1, 1'b0, 1'b1, 32'h2004, 32'h2004);
      #1 checkOutput("right_target_hit", 32'(nextHit), 32'd1);
      stepCycle();
      applyStimulus(32'h1004, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      #1 checkOutput("system_branch_hit", 32'(nextHit), 32'd0);
      stepCycle();
      clearBranch();
      lookup(32'h1004);
      checkOutput("wrong_target_rewrite", fetchPredAddr, 32'h2004);

      $display("[TB] flush concurrent with update");
      applyStimulus(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000);
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      clearBranch();
      countWalk("walk_len_after_flush");
      lookup(32'h1000);
      checkOutput("flushed_ena", 32'(fetchPredEna), 32'd0);

      $display("[TB] aliasing and same-cycle lookup");
      applyStimulus(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000);
      stepCycle();
      applyStimulus(32'h1040, 1'b1, 1'b0, 1'b0, 32'h0, 32'h7040);
      stepCycle();
      clearBranch();
      lookup(32'h1000);
      checkOutput("alias_old_ena", 32'(fetchPredEna), 32'd0);
      lookup(32'h1040);
      checkOutput("alias_new_ena", 32'(fetchPredEna), 32'd1);
      checkOutput("alias_new_addr", fetchPredAddr, 32'h7040);
      applyStimulus(32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2000);
      lookup(32'h1000);
      checkOutput("same_cycle_pre_update", 32'(fetchPredEna), 32'd0);
      clearBranch();
      lookup(32'h1000);
      checkOutput("after_same_cycle", 32'(fetchPredEna), 32'd1);

      $display("[TB] reset during walk");
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      for (int i = 0; i < 5; i++) stepCycle();
      #2 resetN = 1'b0;
      #1;
      checkOutput("midwalk_reset_busy", 32'(busy), 32'd1);
      checkOutput("midwalk_reset_addr", fetchPredAddr, 32'h0);
      modelReset();
      @(negedge clock);
      resetN = 1'b1;
      countWalk("walk_len_after_midwalk_reset");

      $display("[TB] randomized traffic");
      for (int n = 0; n < 600; n++) begin
         fetchReq     = ($urandom_range(3) != 0);
         fetchAddr    = 32'h1000 + 32'h40 * $urandom_range(1) + 32'h4 * $urandom_range(3);
         flush        = ($urandom_range(59) == 0);
         stateNormal  = ($urandom_range(7) != 0);
         prevValid    = ($urandom_range(3) != 0);
         prevExBranch = ($urandom_range(5) != 0);
         nextBusy     = ($urandom_range(5) == 0);
         branchPc     = 32'h1000 + 32'h40 * $urandom_range(1) + 32'h4 * $urandom_range(3);
         branchValid  = ($urandom_range(2) != 0);
         ibValid      = ($urandom_range(4) == 0);
         predEna      = $urandom_range(1);
         jumpAddr     = 32'h8000 + 32'h4 * $urandom_range(3);
         predAddr     = ($urandom_range(1) != 0) ? jumpAddr : 32'h8000 + 32'h4 * $urandom_range(3);
         stepCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
